// File: rtl/clip_sequencer.sv
// clip_sequencer: paces voice-clip record and playback transfers.
// Ports: clock/reset; enableTimer/enableDes/enableS mode enables;
//   startAddress clip base; desValid/desData deserializer input;
//   memAddress/memWrite/memWriteData/memRead/memReadData clip RAM;
//   serLoad/serData serializer output; secondMarker clip-done pulse.
module clip_sequencer #(
    parameter int SAMPLE_DIV   = 6250,
    parameter int CLIP_SAMPLES = 16000,
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enableTimer,
    input  logic              enableDes,
    input  logic              enableS,
    input  logic [ADDR_W-1:0] startAddress,
    input  logic              desValid,
    input  logic [DATA_W-1:0] desData,
    output logic [ADDR_W-1:0] memAddress,
    output logic              memWrite,
    output logic [DATA_W-1:0] memWriteData,
    output logic              memRead,
    input  logic [DATA_W-1:0] memReadData,
    output logic              serLoad,
    output logic [DATA_W-1:0] serData,
    output logic              secondMarker
);

    localparam int OFF_W = $clog2(CLIP_SAMPLES + 1);
    localparam int DIV_W =
        (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [OFF_W-1:0] OFF_LAST =
        OFF_W'(CLIP_SAMPLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST =
        DIV_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        PLAY,
        DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [OFF_W-1:0]  off_q;
    logic [DIV_W-1:0]  div_q;
    // end_q: the final clip sample has been read in PLAY
    logic              end_q;
    // rd_pend_q: RAM data for the last tick arrives this cycle
    logic              rd_pend_q;
    logic              serLoad_q;
    logic [DATA_W-1:0] serData_q;
    logic              marker_q;
    logic              tick;

    assign memAddress   = base_q + ADDR_W'(off_q);
    assign tick         = (state_q == PLAY) &&
                          (div_q == DIV_LAST) && !end_q;
    assign memRead      = tick;
    // marker_q in RECORD means the clip is full: no more writes
    assign memWrite     = (state_q == RECORD) &&
                          desValid && !marker_q;
    assign memWriteData = memWrite ? desData : '0;
    assign serLoad      = serLoad_q;
    assign serData      = serData_q;
    assign secondMarker = marker_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            off_q     <= '0;
            div_q     <= '0;
            end_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            serLoad_q <= 1'b0;
            serData_q <= '0;
            marker_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    end_q     <= 1'b0;
                    rd_pend_q <= 1'b0;
                    serLoad_q <= 1'b0;
                    marker_q  <= 1'b0;
                    if (enableTimer &&
                        (enableDes || enableS)) begin
                        state_q <= enableDes ? RECORD : PLAY;
                        base_q  <= startAddress;
                        off_q   <= '0;
                        div_q   <= '0;
                    end
                end
                RECORD: begin
                    if (!enableTimer || !enableDes) begin
                        state_q  <= IDLE;
                        marker_q <= 1'b0;
                    end else if (marker_q) begin
                        state_q  <= DONE;
                        marker_q <= 1'b0;
                    end else if (desValid) begin
                        if (off_q == OFF_LAST) begin
                            marker_q <= 1'b1;
                        end else begin
                            off_q <= off_q + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (!enableTimer || !enableS) begin
                        state_q   <= IDLE;
                        end_q     <= 1'b0;
                        rd_pend_q <= 1'b0;
                        serLoad_q <= 1'b0;
                        marker_q  <= 1'b0;
                    end else begin
                        div_q     <= (div_q == DIV_LAST) ?
                                     '0 : div_q + 1'b1;
                        rd_pend_q <= tick;
                        serLoad_q <= rd_pend_q;
                        marker_q  <= rd_pend_q && end_q;
                        if (rd_pend_q) begin
                            serData_q <= memReadData;
                        end
                        if (tick) begin
                            if (off_q == OFF_LAST) begin
                                end_q <= 1'b1;
                            end else begin
                                off_q <= off_q + 1'b1;
                            end
                        end
                        if (marker_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    end_q     <= 1'b0;
                    rd_pend_q <= 1'b0;
                    serLoad_q <= 1'b0;
                    marker_q  <= 1'b0;
                    if (!enableTimer) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clip_sequencer.sv
// tb_clip_sequencer: directed bench for clip_sequencer
// with SAMPLE_DIV=4 and CLIP_SAMPLES=5.
module tb_clip_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enableTimer = 1'b0;
    logic        enableDes = 1'b0;
    logic        enableS = 1'b0;
    logic [16:0] startAddress = '0;
    logic        desValid = 1'b0;
    logic [7:0]  desData = '0;
    logic [16:0] memAddress;
    logic        memWrite;
    logic [7:0]  memWriteData;
    logic        memRead;
    logic [7:0]  memReadData = 8'h00;
    logic        serLoad;
    logic [7:0]  serData;
    logic        secondMarker;

    int errors = 0;
    int checks = 0;

    logic [7:0]  recd [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [16:0] reca [5] = '{17'h00100, 17'h00101, 17'h00102,
                              17'h00103, 17'h00104};
    logic [16:0] plya [5] = '{17'h1FFFE, 17'h1FFFF, 17'h00000,
                              17'h00001, 17'h00002};
    logic [7:0]  plyd [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};

    clip_sequencer #(
        .SAMPLE_DIV  (4),
        .CLIP_SAMPLES(5),
        .ADDR_W      (17),
        .DATA_W      (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enableTimer (enableTimer),
        .enableDes   (enableDes),
        .enableS     (enableS),
        .startAddress(startAddress),
        .desValid    (desValid),
        .desData     (desData),
        .memAddress  (memAddress),
        .memWrite    (memWrite),
        .memWriteData(memWriteData),
        .memRead     (memRead),
        .memReadData (memReadData),
        .serLoad     (serLoad),
        .serData     (serData),
        .secondMarker(secondMarker)
    );

    always #5 clock = ~clock;

    // RAM model: returns the low address byte one cycle after a read
    always @(posedge clock) begin
        if (memRead) memReadData <= memAddress[7:0];
    end

    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic idle_out();
        enableTimer = 0; enableDes = 0; enableS = 0; desValid = 0;
        nxt(); nxt();
    endtask

    task automatic test_reset();
        logic [36:0] got;
        logic [3:0]  st, ex;
        got = {memAddress, memWrite, memWriteData, memRead,
               serLoad, serData, secondMarker};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_init outs=%h exp=0", got);
        end
        nxt(); startAddress = 17'h00010; enableTimer = 1; enableS = 1;
        for (int i = 1; i <= 7; i++) begin
            nxt();
            if (i == 7) reset = 1;
            #1;
            if (i == 6) begin
                checks++;
                if (serLoad !== 1'b1 || serData !== 8'h10) begin
                    errors++;
                    $display("FAIL reset_preplay ld=%b d=%h exp 1/10",
                             serLoad, serData);
                end
            end
        end
        for (int i = 8; i <= 9; i++) begin
            nxt();
            if (i == 9) begin reset = 0; startAddress = 17'h00020; end
            #1;
            got = {memAddress, memWrite, memWriteData, memRead,
                   serLoad, serData, secondMarker};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_outs cyc=%0d outs=%h exp=0", i, got);
            end
        end
        for (int i = 1; i <= 7; i++) begin
            nxt(); #1;
            st = {memRead, serLoad, secondMarker, memWrite};
            ex = {i == 4, i == 6, 1'b0, 1'b0};
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL reset_restart cyc=%0d got=%b exp=%b",
                         i, st, ex);
            end
            if (i == 4) begin
                checks++;
                if (memAddress !== 17'h00020) begin
                    errors++;
                    $display("FAIL reset_addr got=%h exp=00020",
                             memAddress);
                end
            end
        end
        idle_out();
    endtask

    task automatic test_record();
        logic [3:0] st, ex;
        bit w;
        nxt(); startAddress = 17'h00100; enableTimer = 1; enableDes = 1;
        for (int i = 1; i <= 20; i++) begin
            nxt();
            w = (i % 2 == 0) && (i <= 10);
            desValid = (i % 2 == 0);
            desData = w ? recd[i/2-1] : 8'h5A;
            #1;
            st = {memRead, serLoad, secondMarker, memWrite};
            ex = {1'b0, 1'b0, i == 11, w};
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL record_strobes cyc=%0d got=%b exp=%b",
                         i, st, ex);
            end
            if (w) begin
                checks++;
                if (memAddress !== reca[i/2-1] ||
                    memWriteData !== recd[i/2-1]) begin
                    errors++;
                    $display("FAIL record_wr cyc=%0d a=%h d=%h exp %h/%h",
                             i, memAddress, memWriteData,
                             reca[i/2-1], recd[i/2-1]);
                end
            end
        end
        idle_out();
    endtask

    task automatic test_play();
        logic [3:0] st, ex;
        bit rd, ld;
        nxt(); startAddress = 17'h1FFFE; enableTimer = 1; enableS = 1;
        for (int i = 1; i <= 30; i++) begin
            nxt(); #1;
            rd = (i % 4 == 0) && (i <= 20);
            ld = (i >= 6) && ((i - 6) % 4 == 0) && (i <= 22);
            st = {memRead, serLoad, secondMarker, memWrite};
            ex = {rd, ld, i == 22, 1'b0};
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL play_strobes cyc=%0d got=%b exp=%b",
                         i, st, ex);
            end
            if (rd) begin
                checks++;
                if (memAddress !== plya[i/4-1]) begin
                    errors++;
                    $display("FAIL play_addr cyc=%0d got=%h exp=%h",
                             i, memAddress, plya[i/4-1]);
                end
            end
            if (ld) begin
                checks++;
                if (serData !== plyd[(i-6)/4]) begin
                    errors++;
                    $display("FAIL play_data cyc=%0d got=%h exp=%h",
                             i, serData, plyd[(i-6)/4]);
                end
            end
        end
        idle_out();
    endtask

    task automatic test_abort();
        logic [3:0] st, ex;
        nxt(); startAddress = 17'h00040; enableTimer = 1; enableS = 1;
        for (int i = 1; i <= 26; i++) begin
            nxt();
            if (i == 11) enableTimer = 0;
            #1;
            st = {memRead, serLoad, secondMarker, memWrite};
            ex = {i == 4 || i == 8, i == 6 || i == 10, 1'b0, 1'b0};
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL abort_strobes cyc=%0d got=%b exp=%b",
                         i, st, ex);
            end
        end
        startAddress = 17'h00080; enableTimer = 1;
        for (int i = 1; i <= 7; i++) begin
            nxt(); #1;
            st = {memRead, serLoad, secondMarker, memWrite};
            ex = {i == 4, i == 6, 1'b0, 1'b0};
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL abort_restart cyc=%0d got=%b exp=%b",
                         i, st, ex);
            end
            if (i == 4 || i == 6) begin
                checks++;
                if ((i == 4 && memAddress !== 17'h00080) ||
                    (i == 6 && serData !== 8'h80)) begin
                    errors++;
                    $display("FAIL abort_relatch cyc=%0d a=%h d=%h exp 80",
                             i, memAddress, serData);
                end
            end
        end
        idle_out();
    endtask

    task automatic test_priority();
        logic [3:0] st, ex;
        bit w;
        nxt(); startAddress = 17'h00200;
        enableTimer = 1; enableDes = 1; enableS = 1;
        for (int i = 1; i <= 16; i++) begin
            nxt();
            w = (i % 2 == 0) && (i <= 10);
            desValid = w;
            desData = 8'(i);
            #1;
            st = {memRead, serLoad, secondMarker, memWrite};
            ex = {1'b0, 1'b0, i == 11, w};
            checks++;
            if (st !== ex) begin
                errors++;
                $display("FAIL prio_strobes cyc=%0d got=%b exp=%b",
                         i, st, ex);
            end
            if (w) begin
                checks++;
                if (memAddress !== 17'h00200 + 17'(i/2-1)) begin
                    errors++;
                    $display("FAIL prio_addr cyc=%0d got=%h exp=%h",
                             i, memAddress, 17'h00200 + 17'(i/2-1));
                end
            end
        end
        idle_out();
    endtask

    task automatic test_idle();
        logic [9:0] got;
        for (int i = 1; i <= 8; i++) begin
            nxt();
            desValid = (i % 2 == 1);
            desData = 8'hFF;
            #1;
            got = {memWrite, memWriteData, memRead};
            checks++;
            if (got !== '0) begin
                errors++;
                $display("FAIL idle_write cyc=%0d got=%h exp=0", i, got);
            end
        end
        desValid = 0;
    endtask

    initial begin
        nxt(); nxt();
        reset = 0;
        #1;
        test_reset();
        test_record();
        test_play();
        test_abort();
        test_priority();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clip_sequencer.md
Name: clip_sequencer

Overview:
- Responder for the voice-clip controller's enables. The controller asserts enableTimer plus enableDes (record) or enableS (play) and waits for secondMarker.
- This block latches startAddress, paces samples at the audio rate, and generates clip-RAM addresses and strobes.
- Record: writes deserializer samples to RAM. Play: reads RAM and loads the serializer.
- Pulses secondMarker when a full clip has been transferred.

Parameters:
- SAMPLE_DIV, 6250, clock cycles per sample period (100 MHz / 16 kHz).
- CLIP_SAMPLES, 16000, samples per clip (one second).
- ADDR_W, 17, clip-RAM address width.
- DATA_W, 8, sample width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enableTimer  in  1  controller: clip transfer active
- enableDes  in  1  controller: record mode
- enableS  in  1  controller: play mode
- startAddress  in  ADDR_W  base address of selected clip; sampled at transfer start
- desValid  in  1  deserializer holds a complete sample (1-cycle pulse)
- desData  in  DATA_W  deserializer sample
- memAddress  out  ADDR_W  clip-RAM address
- memWrite  out  1  RAM write strobe
- memWriteData  out  DATA_W  RAM write data
- memRead  out  1  RAM read strobe; data returned the next cycle
- memReadData  in  DATA_W  RAM read data
- serLoad  out  1  load pulse to serializer
- serData  out  DATA_W  sample to serializer
- secondMarker  out  1  one-cycle pulse: clip complete

Behaviour:
- Reset (any state, any cycle): state IDLE.
- All outputs are 0 after reset. Divider, offset and base registers are cleared.
- States: IDLE, RECORD, PLAY, DONE.
- IDLE exits:
  - enableTimer && enableDes goes to RECORD.
  - enableTimer && enableS && !enableDes goes to PLAY. Record wins if both are set.
  - On either exit: base <= startAddress, offset <= 0, divider <= 0.
- memAddress = base + offset, truncated to ADDR_W. Wraps modulo 2^ADDR_W; no error is flagged.
- RECORD:
  - Each desValid: memWrite=1 and memWriteData=desData in the same cycle, at the current memAddress. Offset increments the next cycle.
  - The divider is unused; the deserializer sets the pace.
  - The write at offset CLIP_SAMPLES-1 is the last one. secondMarker pulses the following cycle, then state goes to DONE.
- PLAY:
  - The divider counts 0..SAMPLE_DIV-1 and wraps; a tick occurs when it equals SAMPLE_DIV-1.
  - On tick cycle T: memRead=1 at the current memAddress.
  - At T+1: capture memReadData.
  - At T+2: serLoad=1 for one cycle, with serData holding the captured value (serData holds until the next load).
  - Offset increments at T+1.
  - After the serLoad for offset CLIP_SAMPLES-1: secondMarker pulses in that same cycle (T+2), then state goes to DONE.
- DONE: all strobes are 0. Return to IDLE when enableTimer=0. A new start is never accepted directly from DONE.
- Abort: enableTimer falling, or the active mode enable falling, in RECORD or PLAY:
  - Next state IDLE; no secondMarker.
  - Strobes drop the next cycle, and in-flight read data is discarded.
- Strobes memWrite, memRead, serLoad and secondMarker are never high outside their states. memWrite and memRead are never high together.
- desValid in any state other than RECORD is ignored.
- The offset counter is sized to ceil(log2(CLIP_SAMPLES+1)) bits and never exceeds CLIP_SAMPLES-1 while active.

Test Plan:
All scenarios use SAMPLE_DIV=4 and CLIP_SAMPLES=5.
1. Reset check: assert reset 2 cycles mid-PLAY.
   - Required: all outputs 0 the next cycle, state IDLE.
   - A subsequent enableS start begins at offset 0.
2. Record: startAddress=0x00100, enableTimer=enableDes=1, 5 desValid pulses with desData=0xA1..0xA5.
   - Required: memWrite at addresses 0x00100..0x00104 with matching data.
   - secondMarker is exactly one cycle, the cycle after the 5th write.
   - With enables still high, state holds DONE and no further writes occur.
3. Play: the RAM model returns addr[7:0]; startAddress=0x1FFFE, enableS=1.
   - Required: memRead every 4 cycles at addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, 0x00002 (wrap).
   - serLoad follows each read by 2 cycles with serData=0xFE, 0xFF, 0x00, 0x01, 0x02.
   - secondMarker coincides with the 5th serLoad.
4. Abort: drop enableTimer after 2 serLoads in PLAY.
   - Required: no further memRead or serLoad, no secondMarker, state IDLE.
   - A restart re-latches startAddress.
5. Priority: enableDes and enableS both set, plus desValid pulses.
   - Required: RECORD entered; memRead never asserted.
6. Idle stimulus: desValid pulses while in IDLE and in DONE.
   - Required: memWrite stays 0.
